// File: rtl/bp_train_sched_pkg.sv
// Shared types and helpers for the perceptron predictor scheduler.
//   bp_op_e      : datapath operation kind (predict / train)
//   state_e      : scheduler FSM states
//   res_entry_t  : resolution FIFO entry at the default widths
//   bp_hash      : perceptron index hash, addr[h+1:2] ^ ghist[h-1:0]
package bp_pkg;

  localparam int unsigned BP_ADDR_WID = 32;
  localparam int unsigned BP_HIST_LEN = 16;
  localparam int unsigned BP_HASH_LEN = 8;

  typedef enum logic {
    BP_OP_PRED  = 1'b0,
    BP_OP_TRAIN = 1'b1
  } bp_op_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRED_WAIT  = 2'd1,
    TRAIN_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [BP_ADDR_WID-1:0] addr;
    logic                   taken;
    logic [BP_HIST_LEN-1:0] ghist;
  } res_entry_t;

  // Width-generic hash: callers zero-extend into 64 bits and truncate the
  // result to their own index width, so non-default parameters still work.
  function automatic logic [63:0] bp_hash(input logic [63:0] addr,
                                          input logic [63:0] ghist,
                                          input int unsigned hash_len);
    logic [63:0] mask;
    mask = (64'd1 << hash_len) - 64'd1;
    return ((addr >> 2) ^ ghist) & mask;
  endfunction

endpackage

// File: rtl/bp_train_sched_if.sv
// Bundle of the scheduler's request, response and datapath signals.
//   master : the environment (front end, back end and weight datapath)
//   slave  : the scheduler itself
interface bp_train_sched_if #(
  parameter int unsigned ADDR_WID           = 32,
  parameter int unsigned PERCEPTRON_HISTORY = 16,
  parameter int unsigned HASH_LENGTH        = 8
);
  logic                          pred_valid;
  logic                          pred_ready;
  logic [ADDR_WID-1:0]           pred_addr;
  logic                          pred_rsp_valid;
  logic                          pred_rsp_taken;
  logic [PERCEPTRON_HISTORY-1:0] pred_rsp_ghist;
  logic                          res_valid;
  logic                          res_ready;
  logic [ADDR_WID-1:0]           res_addr;
  logic                          res_taken;
  logic [PERCEPTRON_HISTORY-1:0] res_ghist;
  logic                          dp_op_valid;
  logic                          dp_op_train;
  logic [HASH_LENGTH-1:0]        dp_idx;
  logic [PERCEPTRON_HISTORY-1:0] dp_ghist;
  logic                          dp_taken;
  logic                          dp_done;
  logic                          dp_pred;

  modport master (
    output pred_valid, pred_addr, res_valid, res_addr, res_taken, res_ghist,
           dp_done, dp_pred,
    input  pred_ready, pred_rsp_valid, pred_rsp_taken, pred_rsp_ghist,
           res_ready, dp_op_valid, dp_op_train, dp_idx, dp_ghist, dp_taken
  );

  modport slave (
    input  pred_valid, pred_addr, res_valid, res_addr, res_taken, res_ghist,
           dp_done, dp_pred,
    output pred_ready, pred_rsp_valid, pred_rsp_taken, pred_rsp_ghist,
           res_ready, dp_op_valid, dp_op_train, dp_idx, dp_ghist, dp_taken
  );
endinterface

// File: rtl/bp_train_sched_res_fifo.sv
// Synchronous FIFO holding branch resolutions awaiting training.
//   push/din   : write when not full
//   pop/dout   : dout shows the head; pop advances when not empty
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit to tell full from empty.
module bp_res_fifo #(
  parameter type         T     = bp_pkg::res_entry_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  T mem_q [DEPTH];
  T mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push && !full) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + PTR_ONE;
    end
    if (pop && !empty) rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only visible behind the pointers.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign dout  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/bp_train_sched.sv
// Scheduler in front of the perceptron weight datapath. Serialises lookups
// and training updates onto the single table port, owns the GHR and the
// index hash, buffers resolutions and bounds lookup-over-train starvation.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lookup request/response, resolution request, datapath issue
module bp_train_sched
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_WID           = 32,
  parameter int unsigned PERCEPTRON_HISTORY = 16,
  parameter int unsigned HASH_LENGTH        = 8,
  parameter int unsigned UPD_DEPTH          = 4,
  parameter int unsigned STARVE_MAX         = 7
) (
  input logic             clk,
  input logic             rst_n,
  bp_train_sched_if.slave bus
);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned PH = PERCEPTRON_HISTORY;

  typedef struct packed {
    logic [ADDR_WID-1:0] addr;
    logic                taken;
    logic [PH-1:0]       ghist;
  } entry_t;

  state_e        state_q, state_d;
  logic [PH-1:0] ghr_q, ghr_d;
  logic [PH-1:0] snap_q, snap_d;
  logic [SW-1:0] starve_q, starve_d;

  entry_t push_entry, head;
  logic   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic   issue_train, issue_pred, starve_hit;
  bp_op_e op;

  function automatic logic [HASH_LENGTH-1:0] index_of(input logic [ADDR_WID-1:0] addr,
                                                      input logic [PH-1:0]       ghist);
    return HASH_LENGTH'(bp_hash(64'(addr), 64'(ghist), HASH_LENGTH));
  endfunction

  assign push_entry = '{addr: bus.res_addr, taken: bus.res_taken, ghist: bus.res_ghist};

  bp_res_fifo #(
    .T     (entry_t),
    .DEPTH (UPD_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue decision: training wins when the FIFO is full, the lookup stream
  // has used up its allowance, or there is simply no lookup waiting.
  always_comb begin
    starve_hit  = (starve_q == SW'(STARVE_MAX));
    issue_train = (state_q == IDLE) && !fifo_empty &&
                  (fifo_full || starve_hit || !bus.pred_valid);
    issue_pred  = (state_q == IDLE) && !issue_train && bus.pred_valid;
    op          = issue_train ? BP_OP_TRAIN : BP_OP_PRED;
    fifo_push   = bus.res_valid && !fifo_full;
    fifo_pop    = issue_train;
  end

  always_comb begin
    state_d  = state_q;
    ghr_d    = ghr_q;
    snap_d   = snap_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (issue_train) begin
          ghr_d    = {ghr_q[PH-2:0], head.taken};
          starve_d = '0;
          state_d  = TRAIN_WAIT;
        end else if (issue_pred) begin
          snap_d   = ghr_q;
          // Only lookups that bypass a waiting resolution count towards starvation.
          if (fifo_empty)      starve_d = '0;
          else if (!starve_hit) starve_d = starve_q + SW'(1);
          state_d  = PRED_WAIT;
        end
      end
      PRED_WAIT, TRAIN_WAIT: if (bus.dp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.pred_ready     = issue_pred;
    bus.res_ready      = !fifo_full;
    bus.dp_op_valid    = issue_train | issue_pred;
    bus.dp_op_train    = (issue_train | issue_pred) && (op == BP_OP_TRAIN);
    bus.dp_idx         = '0;
    bus.dp_ghist       = '0;
    bus.dp_taken       = 1'b0;
    if (issue_train) begin
      bus.dp_idx   = index_of(head.addr, head.ghist);
      bus.dp_ghist = head.ghist;
      bus.dp_taken = head.taken;
    end else if (issue_pred) begin
      bus.dp_idx   = index_of(bus.pred_addr, ghr_q);
      bus.dp_ghist = ghr_q;
    end
    bus.pred_rsp_valid = (state_q == PRED_WAIT) && bus.dp_done;
    bus.pred_rsp_taken = bus.pred_rsp_valid && bus.dp_pred;
    bus.pred_rsp_ghist = bus.pred_rsp_valid ? snap_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ghr_q    <= '0;
      snap_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      ghr_q    <= ghr_d;
      snap_q   <= snap_d;
      starve_q <= starve_d;
    end
  end

  // A completion with nothing outstanding indicates a datapath protocol error.
  a_no_done_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(state_q == IDLE && bus.dp_done));

endmodule

// File: tb/tb_bp_train_sched.sv
module tb_bp_train_sched;
  localparam int DEPTH  = 4;
  localparam int STARVE = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_train_sched_if #(.ADDR_WID(32), .PERCEPTRON_HISTORY(16), .HASH_LENGTH(8)) bus ();

  bp_train_sched #(
    .ADDR_WID(32), .PERCEPTRON_HISTORY(16), .HASH_LENGTH(8),
    .UPD_DEPTH(DEPTH), .STARVE_MAX(STARVE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed { logic pr; logic rr; logic opv; logic rspv; } hs_t;
  typedef struct packed { logic train; logic [7:0] idx; logic [15:0] ghist; logic taken; } op_t;
  typedef struct packed { logic taken; logic [15:0] ghist; } rsp_t;
  typedef struct packed { logic [31:0] addr; logic taken; logic [15:0] ghist; } res_t;

  hs_t  hs_q[$];
  op_t  op_q[$];
  rsp_t rsp_q[$];

  // Reference model: pending resolutions, history, lookup allowance, busy kind.
  res_t        m_fifo[$];
  int          m_state;   // 0 free, 1 awaiting lookup result, 2 awaiting training
  logic [15:0] m_ghr, m_snap;
  int          m_starve;
  int          dp_cnt;
  int          fixed_lat;

  int checks = 0;
  int errors = 0;
  int starve_run = 0;
  bit starve_arm = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_idx(input logic [31:0] a, input logic [15:0] g);
    logic [31:0] t;
    t = (a / 4) ^ {16'd0, g};
    return t[7:0];
  endfunction

  task automatic model_reset();
    m_fifo   = {};
    m_state  = 0;
    m_ghr    = '0;
    m_snap   = '0;
    m_starve = 0;
    dp_cnt   = 0;
  endtask

  // One clock of stimulus; the model's expectations for this cycle are queued.
  task automatic cycle(input logic pv, input logic [31:0] pa, input logic rv,
                       input logic [31:0] ra, input logic rt, input logic [15:0] rg,
                       output logic acc_p, output logic acc_r);
    hs_t  h;
    res_t e;
    logic do_train, do_pred;
    @(posedge clk); #1;
    bus.pred_valid = pv; bus.pred_addr = pa;
    bus.res_valid = rv; bus.res_addr = ra; bus.res_taken = rt; bus.res_ghist = rg;
    bus.dp_done = 1'b0; bus.dp_pred = 1'b0;
    if (dp_cnt > 0) begin
      dp_cnt--;
      if (dp_cnt == 0) begin
        bus.dp_done = 1'b1;
        bus.dp_pred = (fixed_lat != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    h = '0;
    h.rr = (m_fifo.size() < DEPTH);
    do_train = (m_state == 0) && (m_fifo.size() > 0) &&
               (m_fifo.size() == DEPTH || m_starve == STARVE || !pv);
    do_pred  = (m_state == 0) && !do_train && pv;
    if (m_state != 0 && bus.dp_done) begin
      if (m_state == 1) begin
        h.rspv = 1'b1;
        rsp_q.push_back('{taken: bus.dp_pred, ghist: m_snap});
      end
      m_state = 0;
    end
    if (do_train) begin
      e = m_fifo.pop_front();
      op_q.push_back('{train: 1'b1, idx: ref_idx(e.addr, e.ghist), ghist: e.ghist, taken: e.taken});
      m_ghr = (m_ghr << 1) | 16'(e.taken);
      m_starve = 0;
      m_state = 2;
    end else if (do_pred) begin
      op_q.push_back('{train: 1'b0, idx: ref_idx(pa, m_ghr), ghist: m_ghr, taken: 1'b0});
      m_snap = m_ghr;
      h.pr = 1'b1;
      if (m_fifo.size() > 0) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
      else m_starve = 0;
      m_state = 1;
    end
    h.opv = do_train | do_pred;
    if (h.opv) dp_cnt = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
    if (rv && h.rr) m_fifo.push_back('{addr: ra, taken: rt, ghist: rg});
    acc_p = do_pred;
    acc_r = rv && h.rr;
    hs_q.push_back(h);
  endtask

  task automatic idle(input int n);
    logic a, b;
    repeat (n) cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 16'd0, a, b);
  endtask

  task automatic send_pred(input logic [31:0] pa);
    logic ap, ar;
    int n = 0;
    do begin
      cycle(1'b1, pa, 1'b0, 32'd0, 1'b0, 16'd0, ap, ar);
      n++;
    end while (!ap && n < 50);
    if (!ap) chk("pred_accept_timeout", 64'(ap), 64'(1));
  endtask

  task automatic send_res(input logic [31:0] ra, input logic rt, input logic [15:0] rg,
                          input logic pv, input logic [31:0] pa);
    logic ap, ar;
    int n = 0;
    do begin
      cycle(pv, pa, 1'b1, ra, rt, rg, ap, ar);
      n++;
    end while (!ar && n < 50);
    if (!ar) chk("res_accept_timeout", 64'(ar), 64'(1));
  endtask

  // Asserts reset one clock after the previous stimulus; optionally holds
  // dp_done high to prove the response path is cleared asynchronously.
  task automatic apply_reset(input logic hold_done);
    @(posedge clk); #1;
    bus.pred_valid = 1'b0; bus.pred_addr = '0; bus.res_valid = 1'b0;
    bus.res_addr = '0; bus.res_taken = 1'b0; bus.res_ghist = '0;
    bus.dp_done = hold_done; bus.dp_pred = hold_done;
    rst_n = 1'b0;
    #1;
    chk("rst_pred_ready",     64'(bus.pred_ready),     64'(0));
    chk("rst_res_ready",      64'(bus.res_ready),      64'(1));
    chk("rst_pred_rsp_valid", 64'(bus.pred_rsp_valid), 64'(0));
    chk("rst_pred_rsp_taken", 64'(bus.pred_rsp_taken), 64'(0));
    chk("rst_pred_rsp_ghist", 64'(bus.pred_rsp_ghist), 64'(0));
    chk("rst_dp_op_valid",    64'(bus.dp_op_valid),    64'(0));
    chk("rst_dp_op_train",    64'(bus.dp_op_train),    64'(0));
    chk("rst_dp_idx",         64'(bus.dp_idx),         64'(0));
    chk("rst_dp_ghist",       64'(bus.dp_ghist),       64'(0));
    chk("rst_dp_taken",       64'(bus.dp_taken),       64'(0));
    #1;
    bus.dp_done = 1'b0; bus.dp_pred = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a cycle, an op or a response.
  initial begin
    hs_t  h;
    op_t  o;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (hs_q.size() > 0) begin
        h = hs_q.pop_front();
        chk("pred_ready",     64'(bus.pred_ready),     64'(h.pr));
        chk("res_ready",      64'(bus.res_ready),      64'(h.rr));
        chk("dp_op_valid",    64'(bus.dp_op_valid),    64'(h.opv));
        chk("pred_rsp_valid", 64'(bus.pred_rsp_valid), 64'(h.rspv));
      end
      if (bus.dp_op_valid) begin
        if (op_q.size() == 0) chk("op_unexpected", 64'(bus.dp_op_valid), 64'(0));
        else begin
          o = op_q.pop_front();
          chk("dp_op_train", 64'(bus.dp_op_train), 64'(o.train));
          chk("dp_idx",      64'(bus.dp_idx),      64'(o.idx));
          chk("dp_ghist",    64'(bus.dp_ghist),    64'(o.ghist));
          chk("dp_taken",    64'(bus.dp_taken),    64'(o.taken));
        end
        if (starve_arm) begin
          if (bus.dp_op_train) begin
            chk("starve_pred_run", 64'(starve_run), 64'(STARVE));
            starve_arm = 1'b0;
          end else starve_run++;
        end
      end
      if (bus.pred_rsp_valid) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 64'(bus.pred_rsp_valid), 64'(0));
        else begin
          r = rsp_q.pop_front();
          chk("pred_rsp_taken", 64'(bus.pred_rsp_taken), 64'(r.taken));
          chk("pred_rsp_ghist", 64'(bus.pred_rsp_ghist), 64'(r.ghist));
        end
      end
    end
  end

  initial begin
    logic ap, ar, pv;
    int n;
    bus.pred_valid = 1'b0; bus.pred_addr = '0; bus.res_valid = 1'b0;
    bus.res_addr = '0; bus.res_taken = 1'b0; bus.res_ghist = '0;
    bus.dp_done = 1'b0; bus.dp_pred = 1'b0;
    fixed_lat = 2;
    model_reset();
    apply_reset(1'b0);

    // Single lookup, then a single resolution trained on an idle port.
    send_pred(32'h0000_0040);
    idle(4);
    send_res(32'h40, 1'b1, 16'h0, 1'b0, 32'd0);
    idle(4);
    send_pred(32'h0000_0040);
    idle(4);

    // Starvation: one resolution queued behind a continuous lookup stream.
    send_pred(32'h100);
    cycle(1'b1, 32'h104, 1'b1, 32'h80, 1'b0, 16'h0, ap, ar);
    starve_run = 0;
    starve_arm = 1'b1;
    repeat (40) cycle(1'b1, 32'($urandom), 1'b0, 32'd0, 1'b0, 16'd0, ap, ar);
    idle(10);

    // FIFO full while the datapath is busy; lookups keep requesting.
    fixed_lat = 8;
    send_pred(32'h200);
    for (int unsigned i = 0; i < 5; i++)
      send_res(32'h1000 + 32'(i * 4), 1'(i), 16'(i * 3), 1'b1, 32'h300);
    fixed_lat = 1;
    repeat (30) cycle(1'b1, 32'($urandom), 1'b0, 32'd0, 1'b0, 16'd0, ap, ar);
    idle(20);

    // Hash wrap: eight taken trainings from reset fill GHR with 0x00FF.
    apply_reset(1'b0);
    for (int unsigned i = 0; i < 8; i++)
      send_res(32'($urandom), 1'b1, 16'($urandom), 1'b0, 32'd0);
    idle(30);
    send_pred(32'h0000_03FC);
    idle(4);

    // Reset while a lookup is outstanding: no response may follow.
    fixed_lat = 5;
    send_pred(32'h40);
    apply_reset(1'b1);
    idle(10);

    // Randomised traffic.
    fixed_lat = 0;
    pv = 1'b0;
    for (int unsigned i = 0; i < 1500; i++) begin
      if (!pv || $urandom_range(0, 9) < 2) pv = ($urandom_range(0, 9) < 6);
      cycle(pv, 32'($urandom), ($urandom_range(0, 9) < 4), 32'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom), ap, ar);
      if (ap) pv = 1'b0;
    end

    n = 0;
    while ((m_state != 0 || m_fifo.size() != 0 || dp_cnt != 0) && n < 200) begin
      idle(1);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'(m_fifo.size()), 64'(0));
    idle(2);
    @(negedge clk); #1;
    chk("ops_outstanding",  64'(op_q.size()),  64'(0));
    chk("rsps_outstanding", 64'(rsp_q.size()), 64'(0));
    chk("starve_train_seen", 64'(starve_arm),  64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1);
  end

endmodule
